// File: rtl/rxdma_dfis_pkg.sv
// rtl/rxdma_dfis_pkg.sv - shared constants, error codes and FSM encoding for the RX DMA data mover
package rxdma_dfis_pkg;

  localparam logic [7:0] FIS_DATA = 8'h46;

  localparam int SOF_BIT = 32;
  localparam int EOF_BIT = 33;
  localparam int BAD_BIT = 34;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_OVERFLOW = 2'd1,
    ERR_BAD_FIS  = 2'd2,
    ERR_FIS_TYPE = 2'd3
  } err_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HDR,
    ST_FILL,
    ST_REQ,
    ST_DATA,
    ST_NEXT,
    ST_DRAIN,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/rxdma_stage_buf.sv
// rtl/rxdma_stage_buf.sv - burst staging register file with fill (write) and beat (read) pointers
module rxdma_stage_buf #(
  parameter int C_BURST = 16,
  parameter int PTR_W   = $clog2(C_BURST) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  output logic [PTR_W-1:0] fill,
  output logic [PTR_W-1:0] beat,
  output logic [31:0]      rd_data
);

  localparam int IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] BURST_P = PTR_W'(C_BURST);

  logic [31:0]      mem_q [C_BURST];
  logic [31:0]      mem_d [C_BURST];
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0] beat_q, beat_d;

  // clr wins so the last beat of a burst and a discard both rewind cleanly
  always_comb begin
    mem_d  = mem_q;
    fill_d = fill_q;
    beat_d = beat_q;
    if (clr) begin
      fill_d = '0;
      beat_d = '0;
    end else begin
      if (wr_en && (fill_q < BURST_P)) begin
        mem_d[fill_q[IDX_W-1:0]] = wr_data;
        fill_d = fill_q + 1'b1;
      end
      if (rd_en) begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_BURST; i++) begin
        mem_q[i] <= '0;
      end
      fill_q <= '0;
      beat_q <= '0;
    end else begin
      mem_q  <= mem_d;
      fill_q <= fill_d;
      beat_q <= beat_d;
    end
  end

  assign fill    = fill_q;
  assign beat    = beat_q;
  assign rd_data = mem_q[beat_q[IDX_W-1:0]];

endmodule

// File: rtl/rxdma_dfis.sv
// rtl/rxdma_dfis.sv - receive DMA: checks Data FIS headers and writes payload to host memory in bursts
module rxdma_dfis
  import rxdma_dfis_pkg::*;
#(
  parameter int C_BURST = 16,
  parameter int C_LEN_W = 22
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [35:0]        rxll2rxdma_rd_do,
  input  logic               rxll2rxdma_rd_empty,
  input  logic               rxll2rxdma_rd_eof_rdy,
  output logic               rxdma2rxll_rd_en,
  input  logic               port2rxdma_start,
  input  logic [31:0]        port2rxdma_addr,
  input  logic [C_LEN_W-1:0] port2rxdma_len,
  input  logic               port2rxdma_abort,
  output logic               rxdma2port_busy,
  output logic               rxdma2port_done,
  output logic [1:0]         rxdma2port_err,
  output logic [C_LEN_W-1:0] rxdma2port_xfer_cnt,
  output logic               rxdma2mem_req,
  output logic [31:0]        rxdma2mem_addr,
  output logic [5:0]         rxdma2mem_len,
  input  logic               mem2rxdma_ack,
  output logic [31:0]        rxdma2mem_wdata,
  output logic               rxdma2mem_wvalid,
  output logic               rxdma2mem_wlast,
  input  logic               mem2rxdma_wready
);

  localparam int PTR_W = $clog2(C_BURST) + 1;
  localparam logic [PTR_W-1:0] BURST_P = PTR_W'(C_BURST);

  state_e             state_q, state_d;
  logic [31:0]        cur_addr_q, cur_addr_d;
  logic [C_LEN_W-1:0] remaining_q, remaining_d;
  logic [C_LEN_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic               fis_end_q, fis_end_d;
  err_e               err_pend_q, err_pend_d;
  logic               abort_q, abort_d;

  logic               buf_clr, buf_wr, buf_rd;
  logic [PTR_W-1:0]   fill, beat;
  logic [31:0]        buf_rdata;

  logic               w_sof, w_eof, w_bad, hdr_ok, abort_now, last_beat;
  logic [C_LEN_W-1:0] fill_bytes;
  logic [31:0]        fill_addr;
  logic               unused_rsvd;

  assign w_sof       = rxll2rxdma_rd_do[SOF_BIT];
  assign w_eof       = rxll2rxdma_rd_do[EOF_BIT];
  assign w_bad       = rxll2rxdma_rd_do[BAD_BIT];
  assign unused_rsvd = rxll2rxdma_rd_do[35];
  assign hdr_ok      = w_sof && (rxll2rxdma_rd_do[7:0] == FIS_DATA);
  assign abort_now   = port2rxdma_abort || abort_q;
  assign last_beat   = (beat == fill - 1'b1);
  assign fill_bytes  = C_LEN_W'({fill, 2'b00});
  assign fill_addr   = 32'({fill, 2'b00});

  rxdma_stage_buf #(
    .C_BURST (C_BURST),
    .PTR_W   (PTR_W)
  ) u_stage_buf (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_data (rxll2rxdma_rd_do[31:0]),
    .rd_en   (buf_rd),
    .fill    (fill),
    .beat    (beat),
    .rd_data (buf_rdata)
  );

  always_comb begin
    state_d          = state_q;
    cur_addr_d       = cur_addr_q;
    remaining_d      = remaining_q;
    xfer_cnt_d       = xfer_cnt_q;
    fis_end_d        = fis_end_q;
    err_pend_d       = err_pend_q;
    abort_d          = abort_q || (port2rxdma_abort && (state_q != ST_IDLE));
    buf_clr          = 1'b0;
    buf_wr           = 1'b0;
    buf_rd           = 1'b0;
    rxdma2rxll_rd_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (port2rxdma_start) begin
          cur_addr_d  = port2rxdma_addr;
          remaining_d = port2rxdma_len;
          xfer_cnt_d  = '0;
          fis_end_d   = 1'b0;
          err_pend_d  = ERR_OK;
          abort_d     = 1'b0;
          buf_clr     = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort_now) begin
          state_d = ST_FINISH;
        end else if (rxll2rxdma_rd_eof_rdy && !rxll2rxdma_rd_empty) begin
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!rxll2rxdma_rd_empty) begin
          rxdma2rxll_rd_en = 1'b1;
          if (!hdr_ok) begin
            err_pend_d = ERR_FIS_TYPE;
          end
          // a header that is also the eof word leaves nothing to drain
          if (w_eof) begin
            state_d = hdr_ok ? ST_NEXT : ST_FINISH;
          end else if (!hdr_ok || abort_now) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (abort_now) begin
          buf_clr = 1'b1;
          state_d = fis_end_q ? ST_FINISH : ST_DRAIN;
        end else if (fis_end_q) begin
          state_d = (fill != '0) ? ST_REQ : ST_NEXT;
        end else if ((fill == BURST_P) || ((fill != '0) && (fill_bytes == remaining_q))) begin
          state_d = ST_REQ;
        end else if (remaining_q == '0) begin
          err_pend_d = ERR_OVERFLOW;
          state_d    = ST_DRAIN;
        end else if (!rxll2rxdma_rd_empty) begin
          rxdma2rxll_rd_en = 1'b1;
          buf_wr           = 1'b1;
          if (w_eof) begin
            fis_end_d = 1'b1;
            if (w_bad) begin
              err_pend_d = ERR_BAD_FIS;
              buf_clr    = 1'b1;
              state_d    = ST_FINISH;
            end
          end
        end
      end
      ST_REQ: begin
        if (mem2rxdma_ack) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (mem2rxdma_wready) begin
          buf_rd = 1'b1;
          if (last_beat) begin
            buf_clr     = 1'b1;
            cur_addr_d  = cur_addr_q + fill_addr;
            remaining_d = remaining_q - fill_bytes;
            xfer_cnt_d  = xfer_cnt_q + fill_bytes;
            if (abort_now) begin
              state_d = fis_end_q ? ST_FINISH : ST_DRAIN;
            end else begin
              state_d = fis_end_q ? ST_NEXT : ST_FILL;
            end
          end
        end
      end
      ST_NEXT: begin
        fis_end_d = 1'b0;
        state_d   = (abort_now || (remaining_q == '0)) ? ST_FINISH : ST_WAIT;
      end
      ST_DRAIN: begin
        if (!rxll2rxdma_rd_empty) begin
          rxdma2rxll_rd_en = 1'b1;
          if (w_eof) begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        fis_end_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      xfer_cnt_q  <= '0;
      fis_end_q   <= 1'b0;
      err_pend_q  <= ERR_OK;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      xfer_cnt_q  <= xfer_cnt_d;
      fis_end_q   <= fis_end_d;
      err_pend_q  <= err_pend_d;
      abort_q     <= abort_d;
    end
  end

  // an aborted transfer always reports success
  assign rxdma2port_busy     = (state_q != ST_IDLE);
  assign rxdma2port_done     = (state_q == ST_FINISH);
  assign rxdma2port_err      = ((state_q == ST_FINISH) && !abort_q) ? err_pend_q : ERR_OK;
  assign rxdma2port_xfer_cnt = xfer_cnt_q;
  assign rxdma2mem_req       = (state_q == ST_REQ);
  assign rxdma2mem_addr      = cur_addr_q;
  assign rxdma2mem_len       = 6'(fill);
  assign rxdma2mem_wdata     = buf_rdata;
  assign rxdma2mem_wvalid    = (state_q == ST_DATA);
  assign rxdma2mem_wlast     = (state_q == ST_DATA) && last_beat;

endmodule

// File: tb/tb_rxdma_dfis.sv
// tb/tb_rxdma_dfis.sv - scoreboard bench for rxdma_dfis with FIFO and memory-side models
module tb_rxdma_dfis;

  localparam int C_BURST = 16;
  localparam int C_LEN_W = 22;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n;
  logic [35:0]        rxll2rxdma_rd_do;
  logic               rxll2rxdma_rd_empty;
  logic               rxll2rxdma_rd_eof_rdy;
  logic               rxdma2rxll_rd_en;
  logic               port2rxdma_start;
  logic [31:0]        port2rxdma_addr;
  logic [C_LEN_W-1:0] port2rxdma_len;
  logic               port2rxdma_abort;
  logic               rxdma2port_busy;
  logic               rxdma2port_done;
  logic [1:0]         rxdma2port_err;
  logic [C_LEN_W-1:0] rxdma2port_xfer_cnt;
  logic               rxdma2mem_req;
  logic [31:0]        rxdma2mem_addr;
  logic [5:0]         rxdma2mem_len;
  logic               mem2rxdma_ack;
  logic [31:0]        rxdma2mem_wdata;
  logic               rxdma2mem_wvalid;
  logic               rxdma2mem_wlast;
  logic               mem2rxdma_wready;

  always #5 sys_clk = ~sys_clk;

  rxdma_dfis #(
    .C_BURST (C_BURST),
    .C_LEN_W (C_LEN_W)
  ) dut (
    .sys_clk               (sys_clk),
    .sys_rst_n             (sys_rst_n),
    .rxll2rxdma_rd_do      (rxll2rxdma_rd_do),
    .rxll2rxdma_rd_empty   (rxll2rxdma_rd_empty),
    .rxll2rxdma_rd_eof_rdy (rxll2rxdma_rd_eof_rdy),
    .rxdma2rxll_rd_en      (rxdma2rxll_rd_en),
    .port2rxdma_start      (port2rxdma_start),
    .port2rxdma_addr       (port2rxdma_addr),
    .port2rxdma_len        (port2rxdma_len),
    .port2rxdma_abort      (port2rxdma_abort),
    .rxdma2port_busy       (rxdma2port_busy),
    .rxdma2port_done       (rxdma2port_done),
    .rxdma2port_err        (rxdma2port_err),
    .rxdma2port_xfer_cnt   (rxdma2port_xfer_cnt),
    .rxdma2mem_req         (rxdma2mem_req),
    .rxdma2mem_addr        (rxdma2mem_addr),
    .rxdma2mem_len         (rxdma2mem_len),
    .mem2rxdma_ack         (mem2rxdma_ack),
    .rxdma2mem_wdata       (rxdma2mem_wdata),
    .rxdma2mem_wvalid      (rxdma2mem_wvalid),
    .rxdma2mem_wlast       (rxdma2mem_wlast),
    .mem2rxdma_wready      (mem2rxdma_wready)
  );

  logic [31:0] exp_baddr[$];
  int          exp_blen[$];
  logic [32:0] exp_beat[$];
  logic [1:0]  exp_err[$];
  int          exp_cnt[$];
  logic [35:0] src_mem[$];
  int          bi, wi, di, src_rd;
  int          errors, checks;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    rxll2rxdma_rd_empty   = (src_rd >= src_mem.size());
    rxll2rxdma_rd_do      = rxll2rxdma_rd_empty ? 36'h0 : src_mem[src_rd];
    rxll2rxdma_rd_eof_rdy = 1'b0;
    for (int i = src_rd; i < src_mem.size(); i++) begin
      if (src_mem[i][33]) rxll2rxdma_rd_eof_rdy = 1'b1;
    end
  endtask

  // decide and check at negedge, apply the FIFO pop just after posedge
  task automatic step();
    logic do_pop;
    @(negedge sys_clk);
    mem2rxdma_ack    = rxdma2mem_req && ($urandom_range(0, 2) != 0);
    mem2rxdma_wready = ($urandom_range(0, 3) != 0);
    if (rxdma2mem_req && mem2rxdma_ack) begin
      if (bi < exp_baddr.size()) begin
        check_eq("burst_addr", rxdma2mem_addr, exp_baddr[bi]);
        check_eq("burst_len", rxdma2mem_len, exp_blen[bi]);
      end else begin
        check_eq("extra_burst", bi, exp_baddr.size());
      end
      bi++;
    end
    if (rxdma2mem_wvalid && mem2rxdma_wready) begin
      if (wi < exp_beat.size()) check_eq("beat_last_data", {rxdma2mem_wlast, rxdma2mem_wdata}, exp_beat[wi]);
      else check_eq("extra_beat", wi, exp_beat.size());
      wi++;
    end
    if (rxdma2port_done) begin
      if (di < exp_err.size()) begin
        check_eq("done_err", rxdma2port_err, exp_err[di]);
        check_eq("done_xfer_cnt", rxdma2port_xfer_cnt, exp_cnt[di]);
      end else begin
        check_eq("extra_done", di, exp_err.size());
      end
      di++;
    end
    if (rxdma2rxll_rd_en && rxll2rxdma_rd_empty) check_eq("pop_when_empty", rxdma2rxll_rd_en, !rxll2rxdma_rd_empty);
    do_pop = rxdma2rxll_rd_en && !rxll2rxdma_rd_empty;
    @(posedge sys_clk);
    #1;
    if (!sys_rst_n) src_rd = src_mem.size();
    else if (do_pop) src_rd++;
    refresh();
  endtask

  task automatic push_fis(input logic [7:0] typ, input int n, input logic [31:0] base, input bit bad);
    src_mem.push_back({4'b0001, 24'h0, typ});
    for (int i = 0; i < n; i++) begin
      src_mem.push_back({1'b0, bad && (i == n - 1), i == n - 1, 1'b0, base + 32'(i)});
    end
  endtask

  task automatic add_burst(input logic [31:0] addr, input int len, input logic [31:0] base);
    exp_baddr.push_back(addr);
    exp_blen.push_back(len);
    for (int i = 0; i < len; i++) exp_beat.push_back({i == len - 1, base + 32'(i)});
  endtask

  task automatic add_done(input logic [1:0] err, input int cnt);
    exp_err.push_back(err);
    exp_cnt.push_back(cnt);
  endtask

  task automatic start_xfer(input logic [31:0] addr, input int len);
    port2rxdma_addr  = addr;
    port2rxdma_len   = C_LEN_W'(len);
    port2rxdma_start = 1'b1;
    step();
    port2rxdma_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    int target = exp_err.size();
    while (di < target && n < budget) begin
      step();
      n++;
    end
    check_eq("done_seen", di, target);
    check_eq("bursts_used", bi, exp_baddr.size());
    check_eq("beats_used", wi, exp_beat.size());
    check_eq("fifo_drained", src_mem.size() - src_rd, 0);
    check_eq("idle_after_done", rxdma2port_busy, 1'b0);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (wi < target && n < budget) begin
      step();
      n++;
    end
    check_eq("beats_reached", wi >= target, 1'b1);
  endtask

  task automatic check_outs_zero(input string tag);
    check_eq({tag, "_ctl"}, {rxdma2port_busy, rxdma2port_done, rxdma2port_err, rxdma2mem_req,
                             rxdma2mem_wvalid, rxdma2mem_wlast, rxdma2rxll_rd_en}, 0);
    check_eq({tag, "_addr"}, rxdma2mem_addr, 0);
    check_eq({tag, "_wdata"}, rxdma2mem_wdata, 0);
    check_eq({tag, "_cnt_len"}, {rxdma2port_xfer_cnt, rxdma2mem_len}, 0);
  endtask

  initial begin
    errors = 0; checks = 0; bi = 0; wi = 0; di = 0; src_rd = 0;
    sys_rst_n = 1'b0;
    port2rxdma_start = 1'b0; port2rxdma_addr = '0; port2rxdma_len = '0; port2rxdma_abort = 1'b0;
    mem2rxdma_ack = 1'b0; mem2rxdma_wready = 1'b0;
    refresh();
    repeat (3) step();
    check_outs_zero("reset");
    sys_rst_n = 1'b1;
    step();

    // single FIS, single full burst
    push_fis(8'h46, 16, 32'hA000_0000, 0);
    add_burst(32'h1000, 16, 32'hA000_0000);
    add_done(2'd0, 64);
    start_xfer(32'h1000, 64);
    wait_done(400);

    // 40 dwords split 16/16/8; a start while busy is ignored
    push_fis(8'h46, 40, 32'hB000_0000, 0);
    add_burst(32'h1000, 16, 32'hB000_0000);
    add_burst(32'h1040, 16, 32'hB000_0010);
    add_burst(32'h1080, 8, 32'hB000_0020);
    add_done(2'd0, 160);
    start_xfer(32'h1000, 160);
    repeat (10) step();
    start_xfer(32'hDEAD_0000, 4);
    wait_done(800);

    // transfer spanning two Data FIS; no done until the second
    push_fis(8'h46, 8, 32'hC000_0000, 0);
    add_burst(32'h2000, 8, 32'hC000_0000);
    add_burst(32'h2020, 8, 32'hC000_0008);
    start_xfer(32'h2000, 64);
    repeat (60) step();
    check_eq("span_busy_between", rxdma2port_busy, 1'b1);
    check_eq("span_first_burst", wi, exp_beat.size() - 8);
    push_fis(8'h46, 8, 32'hC000_0008, 0);
    add_done(2'd0, 64);
    wait_done(400);

    // FIS longer than the programmed length
    push_fis(8'h46, 12, 32'hD000_0000, 0);
    add_burst(32'h4000, 8, 32'hD000_0000);
    add_done(2'd1, 32);
    start_xfer(32'h4000, 32);
    wait_done(400);

    // wrong FIS type, then bad CRC on eof
    push_fis(8'h34, 6, 32'hE000_0000, 0);
    add_done(2'd3, 0);
    start_xfer(32'h5000, 64);
    wait_done(200);
    push_fis(8'h46, 8, 32'hE100_0000, 1);
    add_done(2'd2, 0);
    start_xfer(32'h5000, 64);
    wait_done(200);

    // address wraps past 2^32
    push_fis(8'h46, 32, 32'h9000_0000, 0);
    add_burst(32'hFFFF_FFC0, 16, 32'h9000_0000);
    add_burst(32'h0000_0000, 16, 32'h9000_0010);
    add_done(2'd0, 128);
    start_xfer(32'hFFFF_FFC0, 128);
    wait_done(600);

    // abort mid-burst: burst completes, rest of FIS drained
    push_fis(8'h46, 40, 32'hF000_0000, 0);
    add_burst(32'h6000, 16, 32'hF000_0000);
    add_done(2'd0, 64);
    start_xfer(32'h6000, 256);
    wait_beats(wi + 3, 300);
    port2rxdma_abort = 1'b1;
    wait_done(800);
    port2rxdma_abort = 1'b0;

    // asynchronous reset mid-burst, then recovery
    push_fis(8'h46, 16, 32'h7000_0000, 0);
    add_burst(32'h7000, 16, 32'h7000_0000);
    start_xfer(32'h7000, 64);
    wait_beats(wi + 4, 300);
    sys_rst_n = 1'b0;
    #1;
    check_outs_zero("midrst");
    bi = exp_baddr.size();
    wi = exp_beat.size();
    repeat (2) step();
    sys_rst_n = 1'b1;
    step();
    check_outs_zero("after_rst");
    push_fis(8'h46, 4, 32'h3300_0000, 0);
    add_burst(32'h3000, 4, 32'h3300_0000);
    add_done(2'd0, 16);
    start_xfer(32'h3000, 16);
    wait_done(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
